// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports (m0 = hart data, m1 = loader/debug)
// plus the single-port RAM macro side. The slave modport is the arbiter's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12
);
  // Requester 0
  logic              m0_valid;
  logic              m0_ready;
  logic [31:0]       m0_addr;
  logic [3:0]        m0_wmask;
  logic [31:0]       m0_wdata;
  logic              m0_rvalid;
  logic [31:0]       m0_rdata;
  // Requester 1
  logic              m1_valid;
  logic              m1_ready;
  logic [31:0]       m1_addr;
  logic [3:0]        m1_wmask;
  logic [31:0]       m1_wdata;
  logic              m1_rvalid;
  logic [31:0]       m1_rdata;
  // RAM macro
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  m0_valid, m0_addr, m0_wmask, m0_wdata,
    output m0_ready, m0_rvalid, m0_rdata,
    input  m1_valid, m1_addr, m1_wmask, m1_wdata,
    output m1_ready, m1_rvalid, m1_rdata,
    output mem_en, mem_addr, mem_wmask, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_valid, m0_addr, m0_wmask, m0_wdata,
    input  m0_ready, m0_rvalid, m0_rdata,
    output m1_valid, m1_addr, m1_wmask, m1_wdata,
    input  m1_ready, m1_rvalid, m1_rdata,
    input  mem_en, mem_addr, mem_wmask, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous word RAM between two requesters.
// Round-robin arbitration with a valid/ready request handshake, combinational grant,
// and a fixed one-cycle response (rvalid for both reads and write acks).
// Optional build macro MEM_ARB_FIXED_PRIO_EN: requester 0 always wins ties
// (priority pinned to requester 0); requester 1 can starve.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   arb
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic {
    PRIO_M0 = 1'b0,
    PRIO_M1 = 1'b1
  } prio_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  prio_e    prio_q, prio_d;
  logic     resp_v_q, resp_v_d;
  logic     resp_id_q, resp_id_d;

  logic     g0_c, g1_c;
  mem_req_t req0_c, req1_c, mem_req_c;
  logic     rvalid0_c, rvalid1_c;

  // Word-aligned RAM requests; upper address bits drop out so accesses wrap.
  assign req0_c = '{addr: arb.m0_addr[ADDR_W+1:2], wmask: arb.m0_wmask, wdata: arb.m0_wdata};
  assign req1_c = '{addr: arb.m1_addr[ADDR_W+1:2], wmask: arb.m1_wmask, wdata: arb.m1_wdata};

  // Byte-offset and out-of-range address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{arb.m0_addr[31:ADDR_W+2], arb.m0_addr[1:0],
                              arb.m1_addr[31:ADDR_W+2], arb.m1_addr[1:0]};

  // Grant: a lone requester always wins, prio breaks ties; nothing is granted in reset.
  always_comb begin
    g0_c = 1'b0;
    g1_c = 1'b0;
    if (!rst) begin
      g0_c = arb.m0_valid & (~arb.m1_valid | (prio_q == PRIO_M0));
      g1_c = arb.m1_valid & (~arb.m0_valid | (prio_q == PRIO_M1));
    end
  end

  // Drive the RAM from the granted requester, all-zero when idle.
  always_comb begin
    mem_req_c = '0;
    if (g0_c) begin
      mem_req_c = req0_c;
    end else if (g1_c) begin
      mem_req_c = req1_c;
    end
  end

  assign arb.mem_en    = g0_c | g1_c;
  assign arb.mem_addr  = mem_req_c.addr;
  assign arb.mem_wmask = mem_req_c.wmask;
  assign arb.mem_wdata = mem_req_c.wdata;

  assign arb.m0_ready  = g0_c;
  assign arb.m1_ready  = g1_c;

  // Next state: response tracking and tie-break rotation.
  always_comb begin
    prio_d    = prio_q;
    resp_v_d  = 1'b0;
    resp_id_d = resp_id_q;
    if (g0_c) begin
      resp_v_d  = 1'b1;
      resp_id_d = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
      prio_d    = PRIO_M0;
`else
      prio_d    = PRIO_M1;
`endif
    end else if (g1_c) begin
      resp_v_d  = 1'b1;
      resp_id_d = 1'b1;
      prio_d    = PRIO_M0;
    end
  end

  // State registers; reset drops any pending response and returns prio to requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q    <= PRIO_M0;
      resp_v_q  <= 1'b0;
      resp_id_q <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      resp_v_q  <= resp_v_d;
      resp_id_q <= resp_id_d;
    end
  end

  // Response steering: RAM read data lands one cycle after the accepting edge.
  assign rvalid0_c = resp_v_q & (resp_id_q == 1'b0);
  assign rvalid1_c = resp_v_q & (resp_id_q == 1'b1);

  assign arb.m0_rvalid = rvalid0_c;
  assign arb.m1_rvalid = rvalid1_c;
  assign arb.m0_rdata  = rvalid0_c ? arb.mem_rdata : '0;
  assign arb.m1_rdata  = rvalid1_c ? arb.mem_rdata : '0;

endmodule
